// File: rtl/adder.sv
// Parameterised unsigned adder with carry-in, carry-out and signed-overflow flag.
// Outputs are either registered (one-cycle latency, out_valid qualifier) or purely combinational.
module adder #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] sum_c;
    logic             carry_c;
    logic             overflow_c;

    always_comb begin
        r          = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum_c      = r[WIDTH-1:0];
        carry_c    = r[WIDTH];
        // Same-sign operands whose result flips sign overflowed in two's complement.
        overflow_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
    end

    generate
        if (REGISTERED) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum       <= '0;
                    carry     <= 1'b0;
                    overflow  <= 1'b0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= in_valid;
                    if (in_valid) begin
                        sum      <= sum_c;
                        carry    <= carry_c;
                        overflow <= overflow_c;
                    end
                end
            end
        end else begin : g_comb
            // clk and rst have no function in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign sum       = sum_c;
            assign carry     = carry_c;
            assign overflow  = overflow_c;
            assign out_valid = in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_adder.sv
// Directed-vector bench for adder: WIDTH=1 combinational, WIDTH=1 registered
// and WIDTH=8 registered instances driven from one sequence of scenario tasks.
module tb_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       iv1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       s1c, c1c, o1c, v1c;
    logic       s1r, c1r, o1r, v1r;

    logic       iv8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] s8;
    logic       c8, o8, v8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    adder #(.WIDTH(1), .REGISTERED(1'b0)) u1c (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .sum(s1c), .carry(c1c), .overflow(o1c), .out_valid(v1c)
    );

    adder #(.WIDTH(1), .REGISTERED(1'b1)) u1r (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(cin1),
        .sum(s1r), .carry(c1r), .overflow(o1r), .out_valid(v1r)
    );

    adder #(.WIDTH(8), .REGISTERED(1'b1)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
        .sum(s8), .carry(c8), .overflow(o8), .out_valid(v8)
    );

    // Expected half-adder results packed as {sum, carry, overflow, out_valid}.
    logic [1:0] hv_ab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [3:0] hv_exp[4] = '{4'b0001, 4'b1001, 4'b1001, 4'b0111};

    task automatic test_reset();
        rst = 1'b1;
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_async_w8 got %b want 0", {s8, c8, o8, v8});
        end
        nvec++;
        if ({s1r, c1r, o1r, v1r} !== 4'd0) begin
            nerr++;
            $display("FAIL reset_async_w1 got %b want 0", {s1r, c1r, o1r, v1r});
        end
        iv8 = 1'b1; a8 = 8'd5; b8 = 8'd6;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_hold_w8 got %b want 0", {s8, c8, o8, v8});
        end
        iv8 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_half_comb();
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = hv_ab[i];
            cin1 = 1'b0;
            iv1  = 1'b1;
            #1;
            nvec++;
            if ({s1c, c1c, o1c, v1c} !== hv_exp[i]) begin
                nerr++;
                $display("FAIL half_comb[%0d] got %b want %b", i, {s1c, c1c, o1c, v1c}, hv_exp[i]);
            end
        end
        iv1 = 1'b0;
        #1;
        nvec++;
        if (v1c !== 1'b0) begin
            nerr++;
            $display("FAIL half_comb_valid got %b want 0", v1c);
        end
        {a1, b1} = 2'b00;
    endtask

    task automatic test_half_reg();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {a1, b1} = hv_ab[i];
            cin1 = 1'b0;
            iv1  = 1'b1;
            #1;
            nvec++;
            if ({s1r, c1r, o1r, v1r} !== ((i == 0) ? 4'b0000 : hv_exp[i-1])) begin
                nerr++;
                $display("FAIL half_reg_pre[%0d] got %b want %b", i, {s1r, c1r, o1r, v1r},
                         (i == 0) ? 4'b0000 : hv_exp[i-1]);
            end
            @(posedge clk);
            #1;
            nvec++;
            if ({s1r, c1r, o1r, v1r} !== hv_exp[i]) begin
                nerr++;
                $display("FAIL half_reg[%0d] got %b want %b", i, {s1r, c1r, o1r, v1r}, hv_exp[i]);
            end
        end
        @(negedge clk);
        iv1 = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if ({s1r, c1r, o1r, v1r} !== 4'b0110) begin
            nerr++;
            $display("FAIL half_reg_drop got %b want 0110", {s1r, c1r, o1r, v1r});
        end
    endtask

    task automatic test_w8_vectors();
        logic [7:0]  va[6] = '{8'd200, 8'd255, 8'd127, 8'd128, 8'd100, 8'd255};
        logic [7:0]  vb[6] = '{8'd100, 8'd0,   8'd1,   8'd128, 8'd27,  8'd255};
        logic        vc[6] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
        // {sum, carry, overflow, out_valid}
        logic [10:0] ve[6] = '{{8'd44, 3'b101}, {8'd0, 3'b101}, {8'd128, 3'b011},
                               {8'd0, 3'b111}, {8'd128, 3'b011}, {8'd255, 3'b101}};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a8 = va[i]; b8 = vb[i]; cin8 = vc[i]; iv8 = 1'b1;
            @(posedge clk);
            #1;
            nvec++;
            if ({s8, c8, o8, v8} !== ve[i]) begin
                nerr++;
                $display("FAIL w8_vec[%0d] got sum=%0d c=%b ov=%b v=%b want sum=%0d c=%b ov=%b v=%b",
                         i, s8, c8, o8, v8, ve[i][10:3], ve[i][2], ve[i][1], ve[i][0]);
            end
        end
        @(negedge clk);
        iv8 = 1'b0; cin8 = 1'b0;
    endtask

    task automatic test_hold();
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4; iv8 = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== {8'd7, 3'b001}) begin
            nerr++;
            $display("FAIL hold_load got sum=%0d v=%b want sum=7 v=1", s8, v8);
        end
        @(negedge clk);
        iv8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            nvec++;
            if ({s8, c8, o8, v8} !== {8'd7, 3'b000}) begin
                nerr++;
                $display("FAIL hold[%0d] got sum=%0d v=%b want sum=7 v=0", i, s8, v8);
            end
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== {8'd44, 3'b101}) begin
            nerr++;
            $display("FAIL stream_pre got %b want %b", {s8, c8, o8, v8}, {8'd44, 3'b101});
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== 11'd0) begin
            nerr++;
            $display("FAIL midreset_async got %b want 0", {s8, c8, o8, v8});
        end
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== 11'd0) begin
            nerr++;
            $display("FAIL midreset_hold got %b want 0", {s8, c8, o8, v8});
        end
        @(negedge clk);
        iv8 = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== 11'd0) begin
            nerr++;
            $display("FAIL release_idle got %b want 0", {s8, c8, o8, v8});
        end
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; iv8 = 1'b1;
        #1;
        nvec++;
        if (v8 !== 1'b0) begin
            nerr++;
            $display("FAIL release_pre got v=%b want 0", v8);
        end
        @(posedge clk);
        #1;
        nvec++;
        if ({s8, c8, o8, v8} !== {8'd3, 3'b001}) begin
            nerr++;
            $display("FAIL release_first got sum=%0d v=%b want sum=3 v=1", s8, v8);
        end
        @(negedge clk);
        iv8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_half_comb();
        test_half_reg();
        test_w8_vectors();
        test_hold();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
